// File: rtl/scroll_message_display.sv
// ============================================================================
// Module   : scroll_message_display
// Brief    : Writable message buffer shown through a rotating DIGITS-wide window.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scroll_message_display #(
    parameter int DIGITS   = 4,
    parameter int MSG_LEN  = 8,
    parameter int CHAR_W   = 2,
    parameter int TICK_DIV = 50000000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         dir,
    input  logic                         step,
    input  logic                         wr_en,
    input  logic [$clog2(MSG_LEN)-1:0]   wr_addr,
    input  logic [CHAR_W-1:0]            wr_data,
    output logic [DIGITS*CHAR_W-1:0]     digit_codes,
    output logic [$clog2(MSG_LEN)-1:0]   offset,
    output logic                         wrap
);

    localparam int AW = $clog2(MSG_LEN);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0] c_tick_max = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] c_last     = AW'(MSG_LEN - 1);
    localparam logic [AW:0]   c_len      = (AW + 1)'(MSG_LEN);

    function automatic logic [DIGITS*CHAR_W-1:0] f_init_window();
        logic [DIGITS*CHAR_W-1:0] v;
        v = '0;
        for (int k = 0; k < DIGITS; k++) begin
            v[(DIGITS-1-k)*CHAR_W +: CHAR_W] = CHAR_W'(k % MSG_LEN);
        end
        return v;
    endfunction

    localparam logic [DIGITS*CHAR_W-1:0] c_init_codes = f_init_window();

    logic [PW-1:0]             r_presc_q,  w_presc_d;
    logic [AW-1:0]             r_offset_q, w_offset_d;
    logic                      r_wrap_q,   w_wrap_d;
    logic [CHAR_W-1:0]         r_msg_q [MSG_LEN];
    logic [CHAR_W-1:0]         w_msg_d [MSG_LEN];
    logic [DIGITS*CHAR_W-1:0]  r_codes_q,  w_codes_d;
    logic                      w_tick;
    logic                      w_advance;

    always_comb begin
        w_tick     = enable && (r_presc_q == c_tick_max);
        w_advance  = w_tick || step;
        w_presc_d  = r_presc_q;
        w_offset_d = r_offset_q;
        w_wrap_d   = 1'b0;
        w_msg_d    = r_msg_q;

        // A manual step restarts the prescaler so the next auto tick is a full period away.
        if (w_advance) begin
            w_presc_d = '0;
        end else if (enable) begin
            w_presc_d = r_presc_q + PW'(1);
        end

        if (w_advance) begin
            if (!dir) begin
                w_offset_d = (r_offset_q == c_last) ? '0 : r_offset_q + AW'(1);
                w_wrap_d   = (r_offset_q == c_last);
            end else begin
                w_offset_d = (r_offset_q == '0) ? c_last : r_offset_q - AW'(1);
                w_wrap_d   = (r_offset_q == '0);
            end
        end

        if (wr_en && ({1'b0, wr_addr} < c_len)) begin
            w_msg_d[wr_addr] = wr_data;
        end
    end

    // Per-digit index: k mod MSG_LEN is an elaboration constant, so one conditional
    // subtract suffices at run time.
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        localparam int c_k_mod = k % MSG_LEN;
        logic [AW:0]   w_sum;
        logic [AW-1:0] w_idx;
        assign w_sum = {1'b0, r_offset_q} + (AW + 1)'(c_k_mod);
        assign w_idx = (w_sum >= c_len) ? AW'(w_sum - c_len) : AW'(w_sum);
        assign w_codes_d[(DIGITS-1-k)*CHAR_W +: CHAR_W] = r_msg_q[w_idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc_q  <= '0;
            r_offset_q <= '0;
            r_wrap_q   <= 1'b0;
            r_codes_q  <= c_init_codes;
            for (int i = 0; i < MSG_LEN; i++) begin
                r_msg_q[i] <= CHAR_W'(i);
            end
        end else begin
            r_presc_q  <= w_presc_d;
            r_offset_q <= w_offset_d;
            r_wrap_q   <= w_wrap_d;
            r_codes_q  <= w_codes_d;
            for (int i = 0; i < MSG_LEN; i++) begin
                r_msg_q[i] <= w_msg_d[i];
            end
        end
    end

    assign digit_codes = r_codes_q;
    assign offset      = r_offset_q;
    assign wrap        = r_wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_scroll_message_display.sv
// ============================================================================
// Module   : tb_scroll_message_display
// Brief    : Directed vector bench for scroll_message_display (6-char buffer, 4 digits).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scroll_message_display;

    localparam int DIGITS   = 4;
    localparam int MSG_LEN  = 6;
    localparam int CHAR_W   = 3;
    localparam int TICK_DIV = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        dir;
    logic        step;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [2:0]  wr_data;
    logic [11:0] digit_codes;
    logic [2:0]  offset;
    logic        wrap;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        en;
        logic        dr;
        logic        st;
        logic        we;
        logic [2:0]  addr;
        logic [2:0]  data;
        logic [2:0]  exp_off;
        logic        exp_wrap;
        logic [11:0] exp_codes;
    } vec_t;

    vec_t vecs[$];

    scroll_message_display #(
        .DIGITS  (DIGITS),
        .MSG_LEN (MSG_LEN),
        .CHAR_W  (CHAR_W),
        .TICK_DIV(TICK_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .dir        (dir),
        .step       (step),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .digit_codes(digit_codes),
        .offset     (offset),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] pk(int a, int b, int c, int d);
        return {3'(a), 3'(b), 3'(c), 3'(d)};
    endfunction

    // Window over the power-on message (msg[i] = i).
    function automatic logic [11:0] win(int o);
        return pk(o % 6, (o + 1) % 6, (o + 2) % 6, (o + 3) % 6);
    endfunction

    task automatic add(input logic en, input logic dr, input logic st, input logic we,
                       input int addr, input int data, input int off, input logic wr,
                       input logic [11:0] codes);
        vec_t v;
        v.en = en; v.dr = dr; v.st = st; v.we = we;
        v.addr = 3'(addr); v.data = 3'(data);
        v.exp_off = 3'(off); v.exp_wrap = wr; v.exp_codes = codes;
        vecs.push_back(v);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input int idx, input int off,
                           input logic wr, input logic [11:0] codes);
        chk({name, "_offset"}, idx, 32'(offset), 32'(off));
        chk({name, "_wrap"}, idx, 32'(wrap), 32'(wr));
        chk({name, "_codes"}, idx, 32'(digit_codes), 32'(codes));
    endtask

    initial begin
        // Paused after reset: nothing moves.
        for (int n = 0; n < 20; n++) add(0, 0, 0, 0, 0, 0, 0, 0, win(0));
        // Auto scroll left, tick every 4th edge, wrap on 5->0.
        for (int n = 1; n <= 24; n++)
            add(1, 0, 0, 0, 0, 0, (n / 4) % 6, n == 24, win(((n - 1) / 4) % 6));
        // One tick scrolling right from 0 wraps to 5.
        add(1, 1, 0, 0, 0, 0, 0, 0, win(0));
        add(1, 1, 0, 0, 0, 0, 0, 0, win(0));
        add(1, 1, 0, 0, 0, 0, 0, 0, win(0));
        add(1, 1, 0, 0, 0, 0, 5, 1, win(0));
        add(0, 1, 0, 0, 0, 0, 5, 0, pk(5, 0, 1, 2));
        // Pause with prescaler at 2; resume needs exactly two more enabled edges.
        add(1, 0, 0, 0, 0, 0, 5, 0, win(5));
        add(1, 0, 0, 0, 0, 0, 5, 0, win(5));
        for (int n = 0; n < 10; n++) add(0, 0, 0, 0, 0, 0, 5, 0, win(5));
        add(1, 0, 0, 0, 0, 0, 5, 0, win(5));
        add(1, 0, 0, 0, 0, 0, 0, 1, win(5));
        add(0, 0, 0, 0, 0, 0, 0, 0, win(0));
        // Three manual steps while paused.
        add(0, 0, 1, 0, 0, 0, 1, 0, win(0));
        add(0, 0, 0, 0, 0, 0, 1, 0, win(1));
        add(0, 0, 1, 0, 0, 0, 2, 0, win(1));
        add(0, 0, 0, 0, 0, 0, 2, 0, win(2));
        add(0, 0, 1, 0, 0, 0, 3, 0, win(2));
        add(0, 0, 0, 0, 0, 0, 3, 0, win(3));
        // Step coincident with a tick gives a single advance.
        add(1, 0, 0, 0, 0, 0, 3, 0, win(3));
        add(1, 0, 0, 0, 0, 0, 3, 0, win(3));
        add(1, 0, 0, 0, 0, 0, 3, 0, win(3));
        add(1, 0, 1, 0, 0, 0, 4, 0, win(3));
        add(1, 0, 0, 0, 0, 0, 4, 0, win(4));
        add(1, 0, 0, 0, 0, 0, 4, 0, win(4));
        add(1, 0, 0, 0, 0, 0, 4, 0, win(4));
        add(1, 0, 0, 0, 0, 0, 5, 0, win(4));
        // Step mid-period clears the prescaler.
        add(1, 0, 0, 0, 0, 0, 5, 0, win(5));
        add(1, 0, 1, 0, 0, 0, 0, 1, win(5));
        add(1, 0, 0, 0, 0, 0, 0, 0, win(0));
        add(1, 0, 0, 0, 0, 0, 0, 0, win(0));
        add(1, 0, 0, 0, 0, 0, 0, 0, win(0));
        add(1, 0, 0, 0, 0, 0, 1, 0, win(0));
        add(0, 0, 0, 0, 0, 0, 1, 0, win(1));
        // Stepping right 1->0 is not a wrap.
        add(0, 1, 1, 0, 0, 0, 0, 0, win(1));
        add(0, 0, 0, 0, 0, 0, 0, 0, win(0));
        // Buffer writes: valid, out-of-range, and one coincident with an advance.
        add(0, 0, 0, 1, 0, 7, 0, 0, win(0));
        add(0, 0, 0, 1, 6, 5, 0, 0, pk(7, 1, 2, 3));
        add(0, 0, 0, 0, 0, 0, 0, 0, pk(7, 1, 2, 3));
        add(0, 1, 1, 1, 2, 6, 5, 1, pk(7, 1, 2, 3));
        add(0, 0, 0, 0, 0, 0, 5, 0, pk(5, 7, 1, 6));
        add(0, 1, 1, 0, 0, 0, 4, 0, pk(5, 7, 1, 6));
        add(0, 0, 0, 0, 0, 0, 4, 0, pk(4, 5, 7, 1));

        reset = 1'b1; enable = 0; dir = 0; step = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
        cycle();
        chk_all("reset", 0, 0, 0, win(0));
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            enable = vecs[i].en; dir = vecs[i].dr; step = vecs[i].st;
            wr_en = vecs[i].we; wr_addr = vecs[i].addr; wr_data = vecs[i].data;
            cycle();
            chk_all("vec", i, int'(vecs[i].exp_off), vecs[i].exp_wrap, vecs[i].exp_codes);
        end

        // Reset mid-scroll, with other inputs active, restores every piece of state.
        enable = 1; dir = 0; step = 0; wr_en = 0;
        for (int n = 0; n < 6; n++) cycle();
        chk("pre_reset_offset", 0, 32'(offset), 32'd5);
        reset = 1; step = 1; wr_en = 1; wr_addr = 0; wr_data = 3;
        cycle();
        chk_all("midreset", 0, 0, 0, win(0));
        reset = 0; step = 0; wr_en = 0;
        for (int n = 1; n <= 3; n++) begin
            cycle();
            chk_all("postreset", n, 0, 0, win(0));
        end
        cycle();
        chk_all("postreset", 4, 1, 0, win(0));
        enable = 0;
        cycle();
        chk_all("postreset", 5, 1, 0, win(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/scroll_message_display.md
Name: scroll_message_display

Overview:
Parametrised scrolling-text engine for the multi-digit seven-segment boards. It holds a writable message buffer of MSG_LEN character codes and shows a DIGITS-wide window into that buffer. The window rotates by one character per prescaled tick, in either direction. It supports single-step, pause and a wrap indication. Packed character codes go to per-digit decoders in the top level.

Parameters:
DIGITS, 4, number of display positions in the window (>=1)
MSG_LEN, 8, message buffer length in characters (>=2)
CHAR_W, 2, bits per character code (>=1)
TICK_DIV, 50000000, clk cycles per scroll step while enabled (>=1)

Ports:
clk  input  1  system clock; all state is updated on its rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  1 = the prescaler runs and the display scrolls automatically; 0 = pause
dir  input  1  0 = offset increments (text moves left); 1 = offset decrements (text moves right)
step  input  1  one-cycle pulse; advances the window one position immediately
wr_en  input  1  message buffer write strobe
wr_addr  input  clog2(MSG_LEN)  buffer index to write
wr_data  input  CHAR_W  character code to write
digit_codes  output  DIGITS*CHAR_W  registered window; digit k (0 = leftmost) is at [(DIGITS-1-k)*CHAR_W +: CHAR_W]
offset  output  clog2(MSG_LEN)  current buffer index shown on digit 0
wrap  output  1  one-cycle pulse when offset wraps around

Behaviour:
- Reset (clk edge with reset=1):
  - prescaler = 0, offset = 0, wrap = 0.
  - msg[i] = i mod 2^CHAR_W.
  - digit_codes = initial window: digit k = msg[k mod MSG_LEN].
  - Reset overrides every other input in the same cycle.
- Prescaler counts 0..TICK_DIV-1 only while enable=1.
  - It holds its value while enable=0; it does not clear.
  - tick = enable && prescaler==TICK_DIV-1. On tick the prescaler returns to 0.
  - TICK_DIV=1 gives a tick on every enabled cycle.
- advance = tick || step.
  - tick and step in the same cycle give a single advance.
  - step also clears the prescaler, so the next automatic tick comes a full TICK_DIV enabled cycles later.
  - step works regardless of enable.
- On advance:
  - dir=0: offset <= (offset==MSG_LEN-1) ? 0 : offset+1.
  - dir=1: offset <= (offset==0) ? MSG_LEN-1 : offset-1.
  - dir is sampled in the advance cycle only; changing dir between advances has no other effect.
- wrap is registered, with the same timing as offset.
  - It is 1 for exactly the one cycle following an advance that moved offset MSG_LEN-1->0 (dir=0) or 0->MSG_LEN-1 (dir=1).
  - Otherwise wrap is 0.
- Buffer write:
  - On wr_en=1 with wr_addr<MSG_LEN, msg[wr_addr] <= wr_data at the clk edge.
  - wr_addr>=MSG_LEN is ignored silently.
  - Writes may coincide with an advance; both take effect in that cycle.
- digit_codes is registered from the current offset and buffer contents.
  - Digit k shows msg[(offset+k) mod MSG_LEN].
  - Latency is 1 clk after offset or msg is updated, i.e. 2 edges after the advance or write strobe is sampled.
- DIGITS>MSG_LEN is legal: characters repeat across the window.
- Modulo index arithmetic is done in clog2(MSG_LEN)+1 bits with a conditional subtract. No divider is inferred.
- All outputs are glitch-free registers. There are no combinational paths from inputs to outputs.

Test Plan:
(Bench parameters: DIGITS=4, MSG_LEN=6, CHAR_W=3, TICK_DIV=4.)
1. Reset, then hold enable=0 for 20 cycles -> offset=0, wrap=0, digit codes 0,1,2,3 constant.
2. enable=1, dir=0, run 24 cycles -> offset advances every 4 cycles 0,1,...,5,0. At offset 1 the window is 1,2,3,4. At offset 4 it is 4,5,0,1. wrap pulses once, 1 cycle, at the 5->0 transition.
3. dir=1 from offset 0 with one tick -> offset=5, wrap pulses, window 5,0,1,2.
4. Clear enable when prescaler=2, wait 10 cycles, set enable again -> no advance while paused; next tick 2 enabled cycles after resume.
5. Pulse step with enable=0 three times, then step coincident with a tick -> offset +3, then exactly +1 more (not +2), prescaler restarts.
6. Write msg[0]=7 and wr_addr=6 (invalid) with data 5 at offset 0 -> two edges later digit 0 = 7, and msg is otherwise unchanged. Assert reset in the middle of a scroll -> all state returns to the reset values on the next edge.
